inst_rom_loader: RTL and testbench

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader.sv | 111 +++++++++++
 tb/tb_inst_rom_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a streaming program loader that holds the core in reset.
// Ports: clk/rst, CPU fetch (ce, addr, inst), load stream (ld_*), cpu_hold_o.
module inst_rom_loader #(
    parameter int INST_MEM_NUM      = 1024,
    parameter int INST_MEM_NUM_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [31:0]                addr,
    output logic [31:0]                inst,
    input  logic                       ld_start_i,
    input  logic                       ld_valid_i,
    input  logic [31:0]                ld_data_i,
    input  logic                       ld_last_i,
    output logic                       ld_ready_o,
    output logic                       ld_done_o,
    output logic                       ld_ovf_o,
    output logic [INST_MEM_NUM_LOG2:0] ld_cnt_o,
    output logic                       cpu_hold_o
);

    localparam int CW = INST_MEM_NUM_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(INST_MEM_NUM);

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            we;
    logic [31:0]     mem_q [INST_MEM_NUM];
    logic            unused_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // No reset on the array: the program image survives core resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[cnt_q[CW-2:0]] <= ld_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (ld_start_i) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (ld_start_i) begin
                    // Restart wins over any word presented this cycle.
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (ld_valid_i) begin
                    if (cnt_q < FULL) begin
                        we    = !rst;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (ld_last_i) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign ld_ready_o = (state_q == S_LOAD) && (cnt_q < FULL);
    assign ld_done_o  = (state_q == S_DONE);
    assign ld_ovf_o   = ovf_q;
    assign ld_cnt_o   = cnt_q;
    assign cpu_hold_o = (state_q != S_RUN);

    // Zero-latency fetch; byte offset and high bits are dropped so the
    // address wraps modulo the array size.
    assign inst = (state_q == S_RUN && ce && !rst)
                ? mem_q[addr[INST_MEM_NUM_LOG2+1:2]]
                : 32'h0;

    assign unused_addr = ^{addr[31:INST_MEM_NUM_LOG2+2], addr[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: a 1024-word and a 4-word instance
// share stimulus and are compared against a simple array/counter model.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        ld_start, ld_valid, ld_last;
    logic [31:0] ld_data;

    logic [31:0] inst_b, inst_s;
    logic        ready_b, done_b, ovf_bo, hold_b;
    logic        ready_s, done_s, ovf_so, hold_s;
    logic [10:0] cnt_bo;
    logic [2:0]  cnt_so;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_b [1024];
    logic [31:0] mem_s [4];
    int          cnt_b, cnt_s;
    bit          ovf_b, ovf_s;

    always #5 clk = ~clk;

    inst_rom_loader #(.INST_MEM_NUM(1024), .INST_MEM_NUM_LOG2(10)) u_big (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
        .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_last_i(ld_last), .ld_ready_o(ready_b), .ld_done_o(done_b),
        .ld_ovf_o(ovf_bo), .ld_cnt_o(cnt_bo), .cpu_hold_o(hold_b)
    );

    inst_rom_loader #(.INST_MEM_NUM(4), .INST_MEM_NUM_LOG2(2)) u_small (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_s),
        .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_last_i(ld_last), .ld_ready_o(ready_s), .ld_done_o(done_s),
        .ld_ovf_o(ovf_so), .ld_cnt_o(cnt_so), .cpu_hold_o(hold_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = $urandom;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        cnt_b = 0; cnt_s = 0; ovf_b = 0; ovf_s = 0;
        chk("start_hold", 32'(hold_b), 32'd1);
        chk("start_cnt_b", 32'(cnt_bo), 32'(cnt_b));
        chk("start_cnt_s", 32'(cnt_so), 32'(cnt_s));
        chk("start_ovf_s", 32'(ovf_so), 32'(ovf_s));
    endtask

    task automatic send(input logic [31:0] w, input bit last);
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        chk("ready_b", 32'(ready_b), 32'(cnt_b < 1024));
        chk("ready_s", 32'(ready_s), 32'(cnt_s < 4));
        tick();
        if (cnt_b < 1024) begin mem_b[cnt_b] = w; cnt_b++; end
        else ovf_b = 1;
        if (cnt_s < 4) begin mem_s[cnt_s] = w; cnt_s++; end
        else ovf_s = 1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("cnt_b", 32'(cnt_bo), 32'(cnt_b));
        chk("cnt_s", 32'(cnt_so), 32'(cnt_s));
        chk("ovf_b", 32'(ovf_bo), 32'(ovf_b));
        chk("ovf_s", 32'(ovf_so), 32'(ovf_s));
        chk("done_b", 32'(done_b), 32'(last));
        chk("done_s", 32'(done_s), 32'(last));
        chk("hold_b", 32'(hold_b), 32'd1);
    endtask

    // Idle cycles with valid low; last and data toggled to prove they are ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ld_last = 1'b1;
            ld_data = $urandom;
            tick();
            chk("gap_cnt", 32'(cnt_bo), 32'(cnt_b));
            chk("gap_done", 32'(done_b), 32'd0);
            chk("gap_hold", 32'(hold_b), 32'd1);
        end
        ld_last = 1'b0;
    endtask

    task automatic end_done();
        tick();
        chk("run_done", 32'(done_b), 32'd0);
        chk("run_hold_b", 32'(hold_b), 32'd0);
        chk("run_hold_s", 32'(hold_s), 32'd0);
    endtask

    task automatic rd(input logic [31:0] a);
        ce = 1'b1;
        addr = a;
        #1;
        chk("inst_b", inst_b, mem_b[a[11:2]]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w2;
        int n;
        rst = 1'b1; ce = 1'b1; addr = 32'h0;
        ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = 0;
        cnt_b = 0; cnt_s = 0; ovf_b = 0; ovf_s = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 32'(hold_b), 32'd0);
        chk("rst_cnt", 32'(cnt_bo), 32'd0);
        chk("rst_ovf", 32'(ovf_bo), 32'd0);
        chk("rst_done", 32'(done_b), 32'd0);
        chk("rst_ready", 32'(ready_b), 32'd0);
        chk("rst_inst", inst_b, 32'd0);
        rst = 1'b0;
        tick();

        // Basic three-word load.
        start_load();
        ce = 1'b1; addr = $urandom; #1;
        chk("load_inst_b", inst_b, 32'd0);
        chk("load_inst_s", inst_s, 32'd0);
        send(32'h34011100, 0);
        send(32'h34020020, 0);
        send(32'h3403FF00, 1);
        ld_start = 1'b1;
        end_done();
        ld_start = 1'b0;
        chk("basic_cnt", 32'(cnt_bo), 32'd3);
        ce = 1'b1; addr = 32'h4; #1;
        chk("basic_rd4", inst_b, 32'h34020020);
        addr = 32'h0; #1;
        chk("basic_rd0", inst_b, 32'h34011100);
        ce = 1'b0; #1;
        chk("ce0_inst", inst_b, 32'd0);

        // Gaps between words.
        start_load();
        for (int i = 0; i < 4; i++) begin
            send($urandom, i == 3);
            if (i != 3) idle(2);
        end
        end_done();
        chk("gap_final_cnt", 32'(cnt_bo), 32'd4);
        for (int j = 0; j < 4; j++) rd(32'(j * 4));

        // Random loads with random gaps and wrapped fetch addresses.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 8);
            start_load();
            for (int i = 0; i < n; i++) begin
                send($urandom, i == n - 1);
                if (i != n - 1) idle($urandom_range(0, 2));
            end
            end_done();
            for (int j = 0; j < n; j++)
                rd(32'(j * 4) | ($urandom << 12) | ($urandom & 3));
        end
        rd(32'h1006);

        // Restart in the middle of a load.
        start_load();
        send($urandom, 0);
        w2 = $urandom;
        send(w2, 0);
        start_load();
        send(32'hAAAA0000, 1);
        end_done();
        chk("restart_cnt", 32'(cnt_bo), 32'd1);
        ce = 1'b1; addr = 32'h0; #1;
        chk("restart_rd0", inst_b, 32'hAAAA0000);
        addr = 32'h4; #1;
        chk("restart_rd4", inst_b, w2);
        rd(32'h8);

        // Reset in the middle of a load.
        tick();
        start_load();
        w2 = $urandom;
        send(w2, 0);
        rst = 1'b1;
        #1;
        chk("rstmid_hold", 32'(hold_b), 32'd0);
        chk("rstmid_cnt", 32'(cnt_bo), 32'd0);
        chk("rstmid_ready", 32'(ready_b), 32'd0);
        cnt_b = 0; cnt_s = 0; ovf_b = 0; ovf_s = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_nodone", 32'(done_b), 32'd0);
            chk("rstmid_run", 32'(hold_b), 32'd0);
        end
        ce = 1'b1; addr = 32'h0; #1;
        chk("rstmid_rd0", inst_b, w2);

        // Overflow on the 4-word instance.
        tick();
        start_load();
        for (int i = 0; i < 6; i++) send($urandom, i == 5);
        chk("ovf_flag_s", 32'(ovf_so), 32'd1);
        chk("ovf_cnt_s", 32'(cnt_so), 32'd4);
        chk("ovf_flag_b", 32'(ovf_bo), 32'd0);
        end_done();
        for (int j = 0; j < 4; j++) begin
            ce = 1'b1; addr = 32'(j * 4); #1;
            chk("ovf_rd_s", inst_s, mem_s[j]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
